// File: rtl/alu_exec_pkg.sv
// Shared types for the execute-stage sequencer: ALU opcodes, sequencer states
// and the rule for which opcodes update the carry flag.
package alu_exec_pkg;

  localparam int DATA_WIDTH = 4;

  typedef enum logic [3:0] {
    OP_ADD        = 4'd0,
    OP_ADC        = 4'd1,
    OP_ADC_NO_DEC = 4'd2,
    OP_SUB        = 4'd3,
    OP_SBC        = 4'd4,
    OP_RRC        = 4'd5,
    OP_RLC        = 4'd6,
    OP_CP         = 4'd7,
    OP_AND        = 4'd8,
    OP_OR         = 4'd9,
    OP_XOR        = 4'd10,
    OP_NOT        = 4'd11
  } alu_op;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    EXEC    = 3'd3,
    WRITE   = 3'd4
  } exec_state_t;

  // Logical ops leave C untouched; arithmetic, rotates and compare update it.
  function automatic logic op_updates_carry(alu_op op);
    logic v;
    case (op)
      OP_ADD, OP_ADC, OP_ADC_NO_DEC, OP_SUB,
      OP_SBC, OP_RRC, OP_RLC, OP_CP: v = 1'b1;
      default:                       v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu_exec_flag_reg.sv
// C/Z/D flag storage with independent update enables; on D, set beats clear.
module flag_reg (
  input  logic clk,
  input  logic reset,
  input  logic i_c_en,
  input  logic i_c,
  input  logic i_z_en,
  input  logic i_z,
  input  logic i_set_d,
  input  logic i_clr_d,
  output logic o_c,
  output logic o_z,
  output logic o_d
);

  logic r_c;
  logic r_z;
  logic r_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c <= 1'b0;
      r_z <= 1'b0;
      r_d <= 1'b0;
    end else begin
      if (i_c_en) r_c <= i_c;
      if (i_z_en) r_z <= i_z;
      if (i_set_d)      r_d <= 1'b1;
      else if (i_clr_d) r_d <= 1'b0;
    end
  end

  assign o_c = r_c;
  assign o_z = r_z;
  assign o_d = r_d;

endmodule

// File: rtl/alu_exec.sv
// Execute-stage sequencer: fetches nibble operands, drives the external ALU,
// owns the flags and writes results back. Define ALU_EXEC_B2B_EN to accept start in WRITE.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  alu_op                 op,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [3:0]            b_imm,
  input  logic                  b_is_imm,
  input  logic                  write_back,
  input  logic                  set_decimal,
  input  logic                  clr_decimal,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_en,
  input  logic [3:0]            mem_rdata,
  output logic                  mem_write_en,
  output logic [3:0]            mem_wdata,
  output alu_op                 alu_op_out,
  output logic [3:0]            temp_a,
  output logic [3:0]            temp_b,
  output logic                  flag_carry_in,
  output logic                  flag_decimal_in,
  input  logic [3:0]            alu_out,
  input  logic                  alu_carry,
  input  logic                  alu_zero,
  output logic                  flag_carry,
  output logic                  flag_zero,
  output logic                  flag_decimal,
  output logic                  busy,
  output logic                  done
);

  exec_state_t           r_state;
  exec_state_t           w_state_next;
  alu_op                 r_op;
  logic [ADDR_WIDTH-1:0] r_a_addr;
  logic [ADDR_WIDTH-1:0] r_b_addr;
  logic [3:0]            r_b_imm;
  logic                  r_b_is_imm;
  logic                  r_write_back;
  logic [3:0]            r_temp_a;
  logic [3:0]            r_temp_b;
  logic [3:0]            r_result;
  logic [ADDR_WIDTH-1:0] r_mem_addr;

  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic                  w_mem_read_en;
  logic                  w_mem_write_en;
  logic [3:0]            w_temp_b;
  logic                  w_done;
  logic                  w_flag_upd;
  logic                  w_accept;

`ifdef ALU_EXEC_B2B_EN
  // The WRITE cycle's store lands before the next FETCH_A read, so overlap is safe.
  assign w_accept = start && ((r_state == IDLE) || (r_state == WRITE));
`else
  assign w_accept = start && (r_state == IDLE);
`endif

  always_comb begin
    w_state_next   = r_state;
    w_mem_addr     = r_mem_addr;
    w_mem_read_en  = 1'b0;
    w_mem_write_en = 1'b0;
    w_temp_b       = r_temp_b;
    w_done         = 1'b0;
    w_flag_upd     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = FETCH_A;
      end
      FETCH_A: begin
        w_mem_addr    = r_a_addr;
        w_mem_read_en = 1'b1;
        w_state_next  = FETCH_B;
      end
      FETCH_B: begin
        if (!r_b_is_imm) begin
          w_mem_addr    = r_b_addr;
          w_mem_read_en = 1'b1;
        end
        w_state_next = EXEC;
      end
      EXEC: begin
        // B read data arrives this cycle; pass it straight to the ALU.
        if (!r_b_is_imm) w_temp_b = mem_rdata;
        w_flag_upd   = 1'b1;
        w_state_next = WRITE;
      end
      WRITE: begin
        if (r_write_back) begin
          w_mem_addr     = r_a_addr;
          w_mem_write_en = 1'b1;
        end
        w_done       = 1'b1;
        w_state_next = w_accept ? FETCH_A : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_op         <= OP_ADD;
      r_a_addr     <= '0;
      r_b_addr     <= '0;
      r_b_imm      <= '0;
      r_b_is_imm   <= 1'b0;
      r_write_back <= 1'b0;
      r_temp_a     <= '0;
      r_temp_b     <= '0;
      r_result     <= '0;
      r_mem_addr   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_mem_addr <= w_mem_addr;
      if (w_accept) begin
        r_op         <= op;
        r_a_addr     <= a_addr;
        r_b_addr     <= b_addr;
        r_b_imm      <= b_imm;
        r_b_is_imm   <= b_is_imm;
        r_write_back <= write_back;
      end
      if (r_state == FETCH_B) begin
        r_temp_a <= mem_rdata;
        if (r_b_is_imm) r_temp_b <= r_b_imm;
      end
      if (r_state == EXEC) begin
        r_temp_b <= w_temp_b;
        r_result <= alu_out;
      end
    end
  end

  flag_reg u_flag_reg (
    .clk     (clk),
    .reset   (reset),
    .i_c_en  (w_flag_upd && op_updates_carry(r_op)),
    .i_c     (alu_carry),
    .i_z_en  (w_flag_upd),
    .i_z     (alu_zero),
    .i_set_d (set_decimal),
    .i_clr_d (clr_decimal),
    .o_c     (flag_carry),
    .o_z     (flag_zero),
    .o_d     (flag_decimal)
  );

  assign mem_addr        = w_mem_addr;
  assign mem_read_en     = w_mem_read_en;
  assign mem_write_en    = w_mem_write_en;
  assign mem_wdata       = r_result;
  assign alu_op_out      = r_op;
  assign temp_a          = r_temp_a;
  assign temp_b          = w_temp_b;
  assign flag_carry_in   = flag_carry;
  assign flag_decimal_in = flag_decimal;
  assign busy            = (r_state != IDLE);
  assign done            = w_done;

endmodule
